// File: rtl/vr16_instruction_encoder.sv
// vr16_instruction_encoder: packs decoded VR16 fields into 16-bit instruction
// words and writes them to program memory at an auto-incrementing address.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   restart               sync pulse: pointer/count/flags cleared, back to RUN
//   in_valid / in_ready   field bundle handshake
//   in_opcode, in_rd, in_rs1, in_rs2, in_imm   decoded fields
//   mem_we, mem_addr, mem_wdata                registered memory write port
//   words_written         words written since reset/restart
//   halted, full          HALT written / last address written
//   err, err_code         sticky error flag and cause
//                         (01 imm overflow, 10 jump range, 11 full)
module vr16_instruction_encoder #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [1:0]        in_rd,
  input  logic [1:0]        in_rs1,
  input  logic [1:0]        in_rs2,
  input  logic [11:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [ADDR_W:0]   words_written,
  output logic              halted,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_HALTED = 2'd1;
  localparam logic [1:0] S_FULL   = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;

  localparam logic [1:0] E_NONE = 2'b00;
  localparam logic [1:0] E_IMM  = 2'b01;
  localparam logic [1:0] E_JUMP = 2'b10;
  localparam logic [1:0] E_FULL = 2'b11;

  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [12:0]       DEPTH_13   = 13'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);

  logic [1:0]        state, state_nx;
  logic [ADDR_W-1:0] wptr, wptr_nx;
  logic [ADDR_W:0]   count_nx;
  logic              we_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [15:0]       wdata_nx;
  logic              halted_nx, full_nx, err_nx;
  logic [1:0]        code_nx;

  logic [15:0]       enc_c;
  logic [1:0]        field_err_c;

  // Only RUN accepts; restart overrides a same-cycle bundle.
  assign in_ready = ~reset & ~restart & (state == S_RUN);

  // Field packing and range check for the presented bundle.
  always_comb begin
    enc_c       = 16'h0000;
    field_err_c = E_NONE;
    case (in_opcode)
      4'h0, 4'h2, 4'h4, 4'h6, 4'hB, 4'hC, 4'hD, 4'hE:
        enc_c = {in_opcode, in_rd, in_rs1, in_rs2, 6'b000000};
      4'h1, 4'h3, 4'h5, 4'h7: begin
        enc_c = {in_opcode, in_rd, in_imm[9:0]};
        if (in_imm[11:10] != 2'b00) field_err_c = E_IMM;
      end
      4'h8: begin
        enc_c = {in_opcode, 2'b00, in_rd, in_imm[7:0]};
        if (in_imm[11:8] != 4'h0) field_err_c = E_IMM;
      end
      4'h9: begin
        enc_c = {in_opcode, in_imm};
        if ({1'b0, in_imm} >= DEPTH_13) field_err_c = E_JUMP;
      end
      4'hA:
        enc_c = {in_opcode, in_rd, 10'b0000000000};
      default:
        enc_c = {OP_HALT, 12'h000};
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx  = state;
    wptr_nx   = wptr;
    count_nx  = words_written;
    we_nx     = 1'b0;
    addr_nx   = mem_addr;
    wdata_nx  = mem_wdata;
    halted_nx = halted;
    full_nx   = full;
    err_nx    = err;
    code_nx   = err_code;

    if (restart) begin
      state_nx  = S_RUN;
      wptr_nx   = '0;
      count_nx  = '0;
      halted_nx = 1'b0;
      full_nx   = 1'b0;
      err_nx    = 1'b0;
      code_nx   = E_NONE;
    end else begin
      case (state)
        S_RUN: begin
          if (in_valid) begin
            if (field_err_c != E_NONE) begin
              // Illegal bundle is consumed but never written.
              err_nx   = 1'b1;
              code_nx  = field_err_c;
              state_nx = S_ERROR;
            end else begin
              we_nx    = 1'b1;
              addr_nx  = wptr;
              wdata_nx = enc_c;
              count_nx = words_written + CNT_ONE;
              if (wptr == LAST_ADDR) begin
                full_nx  = 1'b1;
                state_nx = S_FULL;
              end else begin
                wptr_nx = wptr + PTR_ONE;
              end
              // HALT overrides FULL so a later bundle raises no error.
              if (in_opcode == OP_HALT) begin
                halted_nx = 1'b1;
                state_nx  = S_HALTED;
              end
            end
          end
        end
        S_FULL: begin
          if (in_valid) begin
            err_nx  = 1'b1;
            code_nx = E_FULL;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_RUN;
      wptr          <= '0;
      words_written <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      halted        <= 1'b0;
      full          <= 1'b0;
      err           <= 1'b0;
      err_code      <= E_NONE;
    end else begin
      state         <= state_nx;
      wptr          <= wptr_nx;
      words_written <= count_nx;
      mem_we        <= we_nx;
      mem_addr      <= addr_nx;
      mem_wdata     <= wdata_nx;
      halted        <= halted_nx;
      full          <= full_nx;
      err           <= err_nx;
      err_code      <= code_nx;
    end
  end

endmodule
